// File: rtl/exp4_unidade_controle_jogo.sv
// Control unit for the move-by-move game datapath.
// It runs one round per player move. In espera it waits for a move and
// counts the cycles spent there. The game ends in one of three held final
// states: hit, miss or timeout. From a final state, iniciar restarts the
// game through preparacao.

module exp4_unidade_controle_jogo #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        jogada,
    input  logic        igual,
    input  logic        fimC,
    output logic        zeraC,
    output logic        contaC,
    output logic        zeraR,
    output logic        registraR,
    output logic        pronto,
    output logic        acertou,
    output logic        errou,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    // State codes double as the debug display value
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hD
    } t_estado;

    t_estado          r_estado;
    t_estado          w_proximo;
    logic [TW-1:0]    r_timer;
    logic             w_timerFim;

    assign w_timerFim = (r_timer == TW'(TIMEOUT - 1));

    // State register, forced to inicial by the asynchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Timeout timer: counts only while staying in espera.
    // It is cleared whenever espera is left, so it never reaches TIMEOUT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_estado == ESPERA && w_proximo == ESPERA) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Next-state logic. A move seen in the last espera cycle wins over the timeout.
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:     w_proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_proximo = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    w_proximo = REGISTRA;
                end else if (w_timerFim) begin
                    w_proximo = FIM_TIMEOUT;
                end else begin
                    w_proximo = ESPERA;
                end
            end
            REGISTRA:    w_proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    w_proximo = FIM_ERROU;
                end else if (fimC) begin
                    w_proximo = FIM_ACERTOU;
                end else begin
                    w_proximo = PROXIMO;
                end
            end
            PROXIMO:     w_proximo = ESPERA;
            FIM_ACERTOU: w_proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   w_proximo = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT: w_proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     w_proximo = INICIAL;
        endcase
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = 4'hF;
        case (r_estado)
            INICIAL: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h1;
            end
            ESPERA:     db_estado = 4'h2;
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO: db_estado = 4'h5;
            PROXIMO: begin
                contaC    = 1'b1;
                db_estado = 4'h6;
            end
            FIM_ACERTOU: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = 4'hA;
            end
            FIM_ERROU: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = 4'hE;
            end
            FIM_TIMEOUT: begin
                pronto    = 1'b1;
                timeout   = 1'b1;
                db_estado = 4'hD;
            end
            default:    db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_exp4_unidade_controle_jogo.sv
// Self-checking bench for the game control unit. It uses TIMEOUT=10 and TW=4.
// Expected traces are built from game-level plans: waits, move results and
// the last memory word. The bench maps each expected state code to the
// output values given by the output table.

module tb_exp4_unidade_controle_jogo;

    localparam int TIMEOUT = 10;
    localparam int TW      = 4;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    int total;
    int bad;
    int nContaC;
    int nRegistraR;

    typedef struct {
        logic       ini;
        logic       jog;
        logic       ig;
        logic       fc;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t tbl [18];
    vec_t plan [$];

    exp4_unidade_controle_jogo #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    // Free-running clock with a 10-time-unit period
    always #5 clock = ~clock;

    // Expected {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [11:0] expected(input logic [3:0] c);
        logic zc, cc, rr, pr, ac, er, to;
        zc = (c == 4'h0) || (c == 4'h1);
        cc = (c == 4'h6);
        rr = (c == 4'h4);
        ac = (c == 4'hA);
        er = (c == 4'hE);
        to = (c == 4'hD);
        pr = ac || er || to;
        return {c, zc, cc, zc, rr, pr, ac, er, to};
    endfunction

    // Drives the inputs for one cycle, then waits until just after the next rising edge
    task automatic applyStimulus(input logic ini, input logic jog, input logic ig, input logic fc);
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        fimC    = fc;
        @(posedge clock);
        #1;
        if (contaC)    nContaC++;
        if (registraR) nRegistraR++;
    endtask

    // Compares every output against the values expected for one state code
    task automatic checkOutput(input string name, input logic [3:0] expCode);
        logic [11:0] act;
        logic [11:0] req;
        act = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        req = expected(expCode);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (db_estado got %h expected %h)",
                     name, act, req, db_estado, expCode);
        end
    endtask

    // Compares a pulse count against the count the game plan requires
    task automatic checkCount(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Adds one cycle to the random plan
    task automatic addCycle(input logic ini, input logic jog, input logic ig, input logic fc,
                            input logic [3:0] exp);
        vec_t v;
        v.ini  = ini;
        v.jog  = jog;
        v.ig   = ig;
        v.fc   = fc;
        v.exp  = exp;
        v.name = "random";
        plan.push_back(v);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds one random game. Each move has a random wait; a wait of TIMEOUT
    // or more ends the game on timeout. The 4th word is the last address.
    task automatic buildGame();
        int  w;
        logic ig;
        logic fc;
        logic [3:0] res;
        addCycle(1'b1, rb(), rb(), rb(), 4'h1);
        addCycle(rb(), rb(), rb(), rb(), 4'h2);
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(0, 11);
            if (w >= TIMEOUT) begin
                for (int k = 0; k < TIMEOUT; k++)
                    addCycle(rb(), 1'b0, rb(), rb(), (k == TIMEOUT - 1) ? 4'hD : 4'h2);
                for (int k = 0; k < 3; k++)
                    addCycle(1'b0, rb(), rb(), rb(), 4'hD);
                return;
            end
            for (int k = 0; k <= w; k++)
                addCycle(rb(), (k == w), rb(), rb(), (k == w) ? 4'h4 : 4'h2);
            addCycle(rb(), rb(), rb(), rb(), 4'h5);
            ig  = ($urandom_range(0, 4) != 0);
            fc  = (i == 3);
            res = !ig ? 4'hE : (fc ? 4'hA : 4'h6);
            addCycle(rb(), rb(), ig, fc, res);
            if (res != 4'h6) begin
                for (int k = 0; k < 3; k++)
                    addCycle(1'b0, rb(), rb(), rb(), res);
                return;
            end
            addCycle(rb(), rb(), rb(), rb(), 4'h2);
        end
    endtask

    // Directed vectors, then reset, timeout and game sequences, then random games
    initial begin
        clock      = 1'b0;
        reset      = 1'b0;
        iniciar    = 1'b0;
        jogada     = 1'b0;
        igual      = 1'b0;
        fimC       = 1'b0;
        total      = 0;
        bad        = 0;
        nContaC    = 0;
        nRegistraR = 0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "idle"};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, "start"};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2, "prepIgnoresJog"};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, "esperaIgnoresIni"};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, "move1"};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, "registraIgnores"};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h6, "hitNotLast"};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2, "proximoIgnores"};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h4, "move2"};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h5, "cmp2"};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, "missWinsOverFimC"};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hE, "errouHeld"};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, "restartFromErrou"};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2, "espera2"};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, "move3"};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, "cmp3"};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hA, "hitLast"};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, "acertouHeld"};

        #12;
        checkOutput("resetState", 4'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        checkOutput("afterRelease", 4'h0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].ini, tbl[i].jog, tbl[i].ig, tbl[i].fc);
            checkOutput(tbl[i].name, tbl[i].exp);
        end

        // Asynchronous reset in espera with the timer at 5
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restartFromAcertou", 4'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("esperaEntry", 4'h2);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("esperaTimer5", 4'h2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncResetMidGame", 4'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        checkOutput("resetHeldInicial", 4'h0);

        // Timeout appears exactly TIMEOUT cycles after espera entry
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("startAfterReset", 4'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("esperaAfterReset", 4'h2);
        for (int k = 1; k < TIMEOUT; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("waitBeforeTimeout", 4'h2);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeoutExact", 4'hD);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("timeoutHeld", 4'hD);

        // A move in the last espera cycle wins over the timeout
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restartFromTimeout", 4'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("espera10", 4'h2);
        for (int k = 1; k < TIMEOUT; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lastEsperaCycle", 4'h2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("moveWinsOverTimeout", 4'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cmpAfterLateMove", 4'h5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("hitAfterLateMove", 4'hA);

        // Four correct moves; acertou held for 20 cycles
        nContaC    = 0;
        nRegistraR = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, (i == 3));
            if (i < 3)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            checkOutput("acertouHold", 4'hA);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkCount("fourMovesContaC", nContaC, 3);
        checkCount("fourMovesRegistraR", nRegistraR, 4);

        // Wrong second move
        nContaC    = 0;
        nRegistraR = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrongSecondMove", 4'hE);
        checkCount("wrongMoveContaC", nContaC, 1);
        checkCount("wrongMoveRegistraR", nRegistraR, 2);

        // Random games against the plan-built expected trace
        for (int g = 0; g < 25; g++)
            buildGame();
        while (plan.size() > 0) begin
            vec_t v;
            v = plan.pop_front();
            applyStimulus(v.ini, v.jog, v.ig, v.fc);
            checkOutput(v.name, v.exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp4_unidade_controle_jogo.md
# exp4_unidade_controle_jogo

Control unit for the move-by-move game datapath: sequences the address counter, move register and comparator, one round per player move. Unlike the free-running comparison controller, it waits in an `espera` state for each player move and enforces a per-move timeout with an internal counter. It ends in one of three distinguishable final states (hit, miss, timeout) that are held until the next `iniciar`. It sits between the board I/O (`iniciar`, and `jogada` from the datapath edge detector) and the datapath control inputs.

## Interface
- `TIMEOUT`, 5000: cycles allowed in `espera` before timeout; legal range ≥ 2.
- `TW`, 13: timeout counter width; must satisfy 2^TW > TIMEOUT.

- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `iniciar`  in  1  start request, level-sampled.
- `jogada`  in  1  one-cycle pulse: a move was made (from the datapath edge detector).
- `igual`  in  1  comparator: registered move equals memory word.
- `fimC`  in  1  address counter at last address.
- `zeraC`  out  1  clear address counter.
- `contaC`  out  1  increment address counter.
- `zeraR`  out  1  clear move register.
- `registraR`  out  1  load move register.
- `pronto`  out  1  game finished (any final state).
- `acertou`  out  1  all moves correct.
- `errou`  out  1  wrong move.
- `timeout`  out  1  no move within `TIMEOUT` cycles.
- `db_estado`  out  4  state code for the 7-seg debug display.

## Operation
- Moore FSM. State codes, also driven on `db_estado`:
  - inicial 0x0
  - preparacao 0x1
  - espera 0x2
  - registra 0x4
  - comparacao 0x5
  - proximo 0x6
  - fim_acertou 0xA
  - fim_errou 0xE
  - fim_timeout 0xD
- Unused encodings: `db_estado` = 0xF, next state inicial.
- Transitions:
  - inicial: `iniciar` → preparacao, else stay.
  - preparacao → espera.
  - espera: `jogada` → registra; else if timer == TIMEOUT-1 → fim_timeout; else stay.
  - registra → comparacao.
  - comparacao: !`igual` → fim_errou; else `fimC` → fim_acertou; else proximo.
  - proximo → espera.
  - Final states: `iniciar` → preparacao, else stay.
- Outputs, as a function of state:
  - `zeraC`, `zeraR` = 1 in inicial and preparacao.
  - `registraR` = 1 in registra.
  - `contaC` = 1 in proximo.
  - `pronto` = 1 in all three final states.
  - `acertou` = 1 in fim_acertou only; `errou` = 1 in fim_errou only; `timeout` = 1 in fim_timeout only. The three are mutually exclusive.
- Timeout counter, TW bits:
  - Cleared to 0 in every state other than espera.
  - Increments by 1 each cycle spent in espera.
  - Never wraps: it leaves espera at TIMEOUT-1.
- `iniciar` is ignored outside inicial and the final states.
- `jogada` is ignored outside espera.
- `igual`/`fimC` are examined only in comparacao.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to inicial and the timer to 0.
  - Outputs: `zeraC`=1, `zeraR`=1, `db_estado`=0x0, all other outputs 0.
  - Applies at any point mid-game. First transition on the first rising edge after `reset` returns to 1.
- Start: `iniciar` high at edge k in inicial → preparacao during cycle k+1 → espera from k+2.
- Move: `jogada` sampled at edge t in espera →
  - `registraR`=1 during cycle t+1;
  - comparacao during t+2;
  - proximo or a final state during t+3.
- After proximo, espera is re-entered one cycle later with the timer at 0.
- Timeout: espera entered at cycle e; if no `jogada` is sampled, `timeout`/`pronto` = 1 from cycle e+TIMEOUT.
- Simultaneous events: `jogada` in the same cycle as timer == TIMEOUT-1 → the move wins (registra); no timeout.
- Restart from a final state skips inicial (goes straight to preparacao), so the counter and register are cleared before the new game.

## Test plan
Benches use `TIMEOUT`=10, `TW`=4, and a 4-word memory model.
- Reset in espera with timer = 5 → immediately inicial, `db_estado`=0x0, `zeraC`=`zeraR`=1. After release, `iniciar` → `db_estado` 1 then 2.
- Four correct moves (`igual`=1; `fimC`=1 on the 4th) → 3 `contaC` pulses and 4 `registraR` pulses. fim_acertou with `acertou`=`pronto`=1, `db_estado`=0xA, held 20 cycles until `iniciar`.
- Wrong 2nd move (`igual`=0) → fim_errou, `errou`=1, `acertou`=`timeout`=0, `db_estado`=0xE. Exactly 1 `contaC` pulse.
- No `jogada` after entering espera → `timeout`=1, `db_estado`=0xD exactly 10 cycles after espera entry. Repeat with `jogada` on the 10th espera cycle → registra, no timeout.
- `iniciar` held high through a game, and `jogada` pulsed in registra/comparacao → no effect on sequencing. From fim_errou, `iniciar` → preparacao (0x1), counter cleared, new game completes normally.
